// File: rtl/rf_spill_stack.sv
// +------------------------------------------------------------------------+
// | rf_spill_stack: on-chip LIFO holding spilled register-file windows;    |
// | pushes one word per SPILL cycle and pops a full window per FILL pulse. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module rf_spill_stack #(
  parameter int NBITS     = 64,
  parameter int DEPTH     = 64,
  parameter int WIN_WORDS = 16
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         SPILL,
  input  logic [NBITS-1:0]             MEM_BUS,
  input  logic                         FILL,
  output logic [NBITS-1:0]             MEM_BUSread,
  output logic                         FILL_VALID,
  output logic                         FILL_LAST,
  output logic                         BUSY,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT,
  output logic                         OVERFLOW,
  output logic                         UNDERFLOW,
  output logic                         PROTO_ERR
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = $clog2(WIN_WORDS + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] WIN_C   = CW'(WIN_WORDS);
  localparam logic [WW-1:0] WIN_W   = WW'(WIN_WORDS);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_FILLING = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [NBITS-1:0]  rdata_q, rdata_d;
  logic              fvalid_q, fvalid_d;
  logic              flast_q, flast_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              perr_q, perr_d;

  logic [NBITS-1:0]  mem_q [DEPTH];
  logic              we_d;
  logic [AW-1:0]     waddr_d;
  logic [AW-1:0]     raddr_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wcnt_d   = wcnt_q;
    rdata_d  = rdata_q;
    fvalid_d = 1'b0;
    flast_d  = 1'b0;
    busy_d   = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    perr_d   = perr_q;
    we_d     = 1'b0;
    waddr_d  = count_q[AW-1:0];
    raddr_d  = AW'(count_q - CW'(1));

    case (state_q)
      ST_IDLE: begin
        if (SPILL) begin
          // A push always wins over a coincident fill request.
          if (count_q == DEPTH_C) begin
            ovf_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            count_d = count_q + CW'(1);
          end
          if (FILL) begin
            perr_d = 1'b1;
          end
        end else if (FILL) begin
          if (count_q >= WIN_C) begin
            state_d = ST_FILLING;
            wcnt_d  = WIN_W;
            busy_d  = 1'b1;
          end else begin
            udf_d = 1'b1;
          end
        end
      end

      ST_FILLING: begin
        busy_d   = 1'b1;
        if (SPILL || FILL) begin
          perr_d = 1'b1;
        end
        rdata_d  = mem_q[raddr_d];
        fvalid_d = 1'b1;
        count_d  = count_q - CW'(1);
        wcnt_d   = wcnt_q - WW'(1);
        if (wcnt_q == WW'(1)) begin
          flast_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      wcnt_q   <= '0;
      rdata_q  <= '0;
      fvalid_q <= 1'b0;
      flast_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wcnt_q   <= wcnt_d;
      rdata_q  <= rdata_d;
      fvalid_q <= fvalid_d;
      flast_q  <= flast_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      perr_q   <= perr_d;
    end
  end

  // Storage is deliberately left out of reset; COUNT alone defines what is live.
  always_ff @(posedge clk) begin
    if (we_d && !RST) begin
      mem_q[waddr_d] <= MEM_BUS;
    end
  end

  assign MEM_BUSread = rdata_q;
  assign FILL_VALID  = fvalid_q;
  assign FILL_LAST   = flast_q;
  assign BUSY        = busy_q;
  assign COUNT       = count_q;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = udf_q;
  assign PROTO_ERR   = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_spill_stack.sv
// Testbench for rf_spill_stack: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based stack model.
`default_nettype none

module tb_rf_spill_stack;

  localparam int NBITS = 64;
  localparam int DEPTH = 64;
  localparam int WIN   = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             spill = 1'b0;
  logic             fill = 1'b0;
  logic [NBITS-1:0] mem_bus = '0;
  logic [NBITS-1:0] mem_busread;
  logic             fill_valid, fill_last, busy;
  logic [CW-1:0]    count;
  logic             overflow, underflow, proto_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [NBITS-1:0] stk[$];
  int               fill_left = 0;
  logic [NBITS-1:0] e_word = '0;
  logic             e_valid = 1'b0, e_last = 1'b0, e_busy = 1'b0;
  logic             e_ovf = 1'b0, e_udf = 1'b0, e_perr = 1'b0;

  rf_spill_stack #(.NBITS(NBITS), .DEPTH(DEPTH), .WIN_WORDS(WIN)) dut (
    .clk        (clk),
    .RST        (rst),
    .SPILL      (spill),
    .MEM_BUS    (mem_bus),
    .FILL       (fill),
    .MEM_BUSread(mem_busread),
    .FILL_VALID (fill_valid),
    .FILL_LAST  (fill_last),
    .BUSY       (busy),
    .COUNT      (count),
    .OVERFLOW   (overflow),
    .UNDERFLOW  (underflow),
    .PROTO_ERR  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NBITS-1:0] obs, input logic [NBITS-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance, update the model, compare every output.
  task automatic cyc(input bit sp, input logic [NBITS-1:0] d, input bit fl, input bit r);
    rst = r; spill = sp; mem_bus = d; fill = fl;
    @(posedge clk);
    if (r) begin
      stk.delete();
      fill_left = 0;
      e_word = '0; e_valid = 0; e_last = 0; e_busy = 0;
      e_ovf = 0; e_udf = 0; e_perr = 0;
    end else if (fill_left > 0) begin
      if (sp || fl) e_perr = 1;
      e_word  = stk.pop_back();
      e_valid = 1;
      e_last  = (fill_left == 1);
      e_busy  = 1;
      fill_left--;
    end else begin
      e_valid = 0; e_last = 0; e_busy = 0;
      if (sp) begin
        if (stk.size() < DEPTH) stk.push_back(d);
        else e_ovf = 1;
        if (fl) e_perr = 1;
      end else if (fl) begin
        if (stk.size() >= WIN) begin
          fill_left = WIN;
          e_busy = 1;
        end else begin
          e_udf = 1;
        end
      end
    end
    #1;
    chk("word",      mem_busread, e_word);
    chk("valid",     NBITS'(fill_valid), NBITS'(e_valid));
    chk("last",      NBITS'(fill_last),  NBITS'(e_last));
    chk("busy",      NBITS'(busy),       NBITS'(e_busy));
    chk("count",     NBITS'(count),      NBITS'(stk.size()));
    chk("overflow",  NBITS'(overflow),   NBITS'(e_ovf));
    chk("underflow", NBITS'(underflow),  NBITS'(e_udf));
    chk("proto_err", NBITS'(proto_err),  NBITS'(e_perr));
  endtask

  function automatic logic [NBITS-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    // Reset state
    cyc(0, '0, 0, 1);

    // Spill 0x1..0x10 then fill one window
    for (int i = 1; i <= 16; i++) cyc(1, NBITS'(i), 0, 0);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 18; i++) cyc(0, '0, 0, 0);

    // Overflow: 65 pushes, then a fill returns 64..49
    cyc(0, '0, 0, 1);
    for (int i = 1; i <= 65; i++) cyc(1, NBITS'(i), 0, 0);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 18; i++) cyc(0, '0, 0, 0);

    // Underflow with 10 words stored
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, rnd(), 0, 0);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 0, 0);

    // SPILL+FILL together at COUNT=16, then spills/fills during FILLING
    for (int i = 0; i < 6; i++) cyc(1, rnd(), 0, 0);
    cyc(1, rnd(), 1, 0);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(i % 2 == 0, rnd(), i == 7, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0);

    // Reset mid-fill after word 5, then one spill of 0xAA
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, rnd(), 0, 0);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 1);
    cyc(1, 64'hAA, 0, 0);
    cyc(0, '0, 0, 0);

    // Back-to-back fills at E0 and E17 over 32 stored words
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 32; i++) cyc(1, rnd(), 0, 0);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, '0, 0, 0);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 18; i++) cyc(0, '0, 0, 0);

    // Random traffic
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 6, rnd(), $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_spill_stack.md
# rf_spill_stack

Backing store for the windowed register file's SPILL/FILL traffic. When the register file overflows its windows on a CALL, it streams the oldest window out over its memory bus; this block pushes those words onto an on-chip LIFO. When a SIGRETURN needs a window back, the register file raises FILL and this block pops one window's worth of words onto the register file's memory read bus. It sits directly downstream of the register file's SPILL/MEM_BUS outputs and upstream of its MEM_BUSread input.

## Interface
Parameters:
- NBITS, 64, data word width; must match the register file word width.
- DEPTH, 64, stack capacity in words.
- WIN_WORDS, 16, words per window transfer (one FILL request returns exactly this many words).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- SPILL  input  1  push request: each sampled cycle with SPILL=1 pushes MEM_BUS.
- MEM_BUS  input  NBITS  spill data from the register file.
- FILL  input  1  pop-window request, single-cycle pulse.
- MEM_BUSread  output  NBITS  fill data to the register file (registered).
- FILL_VALID  output  1  MEM_BUSread holds a valid popped word this cycle.
- FILL_LAST  output  1  marks the final (WIN_WORDS-th) word of a fill.
- BUSY  output  1  a fill is in progress; new requests are not accepted.
- COUNT  output  $clog2(DEPTH+1)  words currently stored.
- OVERFLOW  output  1  sticky: a push arrived with COUNT==DEPTH.
- UNDERFLOW  output  1  sticky: FILL requested with COUNT<WIN_WORDS.
- PROTO_ERR  output  1  sticky: request arrived while BUSY, or SPILL and FILL arrived together.

## Operation
- States: IDLE, FILLING. Pushes are handled in IDLE; there is no separate spill state.
- IDLE, SPILL=1, FILL=0: if COUNT<DEPTH, write MEM_BUS at address COUNT and increment COUNT. If COUNT==DEPTH, drop the word, leave COUNT unchanged, set OVERFLOW.
- IDLE, FILL=1, SPILL=0, COUNT>=WIN_WORDS: load the word counter with WIN_WORDS and go to FILLING.
- IDLE, FILL=1, COUNT<WIN_WORDS: reject the request, emit no data, set UNDERFLOW, stay in IDLE.
- IDLE, SPILL=1 and FILL=1 in the same cycle: perform the push as above, drop the fill, set PROTO_ERR.
- FILLING: each cycle, pop the word at COUNT-1 into MEM_BUSread, assert FILL_VALID, decrement COUNT and the word counter. On the last word, assert FILL_LAST and return to IDLE.
- Fill order is LIFO: words come back in the reverse of the order they were spilled. The register file indexes accordingly.
- SPILL or FILL sampled while in FILLING: ignored (no push, no extra fill) and PROTO_ERR is set.
- Sticky flags clear only on RST.
- Storage contents are not cleared by RST; only COUNT is. Stale data is unreachable.

## Timing
- Reset values: MEM_BUSread=0, FILL_VALID=0, FILL_LAST=0, BUSY=0, COUNT=0, OVERFLOW=0, UNDERFLOW=0, PROTO_ERR=0, state=IDLE.
- Push: SPILL sampled at edge E. COUNT shows +1 after E. Sustained throughput is 1 word/cycle with no gaps required.
- Fill: FILL sampled at edge E0.
  - BUSY is 1 after E0 through E_WIN_WORDS.
  - Words appear after edges E1..E_WIN_WORDS, one per cycle, with FILL_VALID=1 and COUNT decremented at each of those edges.
  - FILL_LAST=1 only after E_WIN_WORDS.
  - After E_WIN_WORDS+1, BUSY=0, FILL_VALID=0 and MEM_BUSread holds its last value.
  - The earliest new request is sampled at E_WIN_WORDS+1; back-to-back fills therefore have a one-cycle bubble.
- FILL_VALID, FILL_LAST and BUSY are registered outputs; none depends combinationally on inputs.
- RST mid-fill: at the reset edge the fill is aborted, all outputs return to their reset values, and no further words are emitted.
- COUNT arithmetic is unsigned. COUNT never exceeds DEPTH and never goes below 0.

## Test plan
- Spill then fill (WIN_WORDS=16): push 16 words 0x1..0x10 on consecutive cycles, then pulse FILL. Required: COUNT reaches 16; FILL_VALID for 16 cycles carrying 0x10 down to 0x1; FILL_LAST on 0x1; COUNT returns to 0.
- Overflow: push 65 words (DEPTH=64). Required: COUNT=64 and OVERFLOW=1 after word 65. A subsequent fill returns words 64..49, so word 65 was not stored.
- Underflow: with COUNT=10, pulse FILL. Required: UNDERFLOW=1, FILL_VALID never rises, BUSY stays 0, COUNT stays 10.
- Simultaneous and busy requests:
  - SPILL+FILL together with COUNT=16: required push only, COUNT=17, PROTO_ERR=1, no fill.
  - SPILL during FILLING: required to be ignored, with COUNT decrementing normally.
- Reset mid-fill: assert RST at the edge after word 5 of a fill. Required: all outputs 0 on the next cycle. A spill of 0xAA after reset followed by a push-count check gives COUNT=1.
- Back-to-back fills: 32 words stored, FILL pulsed at E0 and again at E17. Required: 32 consecutive-window words in LIFO order with exactly one idle cycle between the two bursts.
